// File: rtl/key_irq_core.sv
// Keyboard interrupt/status stage: KBCODE latch, key/break IRQ pending flags,
// keyboard overrun and the SKSTAT shift/key-down mirror, plus combined IRQ.
module key_irq_core (
  input  logic       clk,
  input  logic       reset,
  input  logic       enn,
  input  logic       setKey,
  input  logic       setBreak,
  input  logic       keyDown,
  input  logic       kShift,
  input  logic [7:0] D,
  input  logic       irqEnWr,
  input  logic [1:0] irqEnData,
  input  logic       skResWr,
  output logic [7:0] kbcode,
  output logic       irqstKeyN,
  output logic       irqstBrkN,
  output logic       skKbOvrN,
  output logic       skShiftN,
  output logic       skKeyDnN,
  output logic       irqN
);

  logic [1:0] irqEn;
  logic       keyPendN, brkPendN, ovrN, shiftN, keyDnN;
  logic       kev, bev;
  logic       keyPendN_nx, brkPendN_nx, ovrN_nx;

  assign kev = setKey & enn;
  assign bev = setBreak & enn;

  // Events use the pre-write enable; a disabling write overrides an event in
  // the same cycle. Overrun sees the prior pending flag and beats SKRES.
  always_comb begin
    keyPendN_nx = keyPendN;
    brkPendN_nx = brkPendN;
    ovrN_nx     = ovrN;
    if (kev && irqEn[1]) keyPendN_nx = 1'b0;
    if (bev && irqEn[0]) brkPendN_nx = 1'b0;
    if (irqEnWr && !irqEnData[1]) keyPendN_nx = 1'b1;
    if (irqEnWr && !irqEnData[0]) brkPendN_nx = 1'b1;
    if (skResWr) ovrN_nx = 1'b1;
    if (kev && !keyPendN) ovrN_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbcode   <= 8'h00;
      irqEn    <= 2'b00;
      keyPendN <= 1'b1;
      brkPendN <= 1'b1;
      ovrN     <= 1'b1;
      shiftN   <= 1'b1;
      keyDnN   <= 1'b1;
    end else begin
      if (kev) kbcode <= D;
      if (irqEnWr) irqEn <= irqEnData;
      keyPendN <= keyPendN_nx;
      brkPendN <= brkPendN_nx;
      ovrN     <= ovrN_nx;
      if (enn) begin
        shiftN <= ~kShift;
        keyDnN <= ~keyDown;
      end
    end
  end

  assign irqstKeyN = keyPendN;
  assign irqstBrkN = brkPendN;
  assign skKbOvrN  = ovrN;
  assign skShiftN  = shiftN;
  assign skKeyDnN  = keyDnN;
  assign irqN      = keyPendN & brkPendN;

endmodule
